// File: rtl/control_pkg.sv
// Shared types for the ID/EX control word: layout, ALU op codes, operand and
// writeback selects, RV32I opcodes. Also consumed by the control_out agent.
package control_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_C4   = 2'd2;
  localparam logic [1:0] WB_ALU     = 2'd0;
  localparam logic [1:0] WB_MEM     = 2'd1;
  localparam logic [1:0] WB_PC4     = 2'd2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [8:0] reserved;
    logic       illegal;
    logic [2:0] branch_funct3;
    logic       is_jalr;
    logic       is_jal;
    logic       is_branch;
    logic [1:0] wb_sel;
    logic       reg_write;
    logic       mem_unsigned;
    logic [1:0] mem_size;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] alu_src_b;
    logic [1:0] alu_src_a;
    alu_op_e    alu_op;
  } control_type;

  typedef enum logic [1:0] {ST_EMPTY, ST_LOADED, ST_BUBBLE} state_e;

  // alt selects SUB/SRA (funct7[5]) where that encoding exists
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational RV32I decode into control_type. CONTROL_OUT_ILLEGAL_TRAP_EN
// makes undecodable encodings produce an illegal-only word instead of a NOP.
module control_decoder
  import control_pkg::*;
(
  input  logic [31:0] instr,
  output control_type ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       bad;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  always_comb begin
    ctrl     = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    bad      = 1'b0;
    case (opcode)
      OP_LUI: begin
        ctrl.alu_op = ALU_PASSB; ctrl.alu_src_a = SRC_A_ZERO;
        ctrl.alu_src_b = SRC_B_IMM; ctrl.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.alu_src_a = SRC_A_PC; ctrl.alu_src_b = SRC_B_IMM; ctrl.reg_write = 1'b1;
      end
      OP_JAL: begin
        ctrl.alu_src_a = SRC_A_PC; ctrl.alu_src_b = SRC_B_IMM;
        ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_PC4; ctrl.is_jal = 1'b1;
      end
      OP_JALR: begin
        bad = (f3 != 3'b000);
        ctrl.alu_src_b = SRC_B_IMM; ctrl.reg_write = 1'b1;
        ctrl.wb_sel = WB_PC4; ctrl.is_jalr = 1'b1; uses_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        bad = (f3 == 3'b010) || (f3 == 3'b011);
        ctrl.alu_op = ALU_SUB; ctrl.is_branch = 1'b1; ctrl.branch_funct3 = f3;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_LOAD: begin
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        ctrl.alu_src_b = SRC_B_IMM; ctrl.mem_read = 1'b1; ctrl.mem_size = f3[1:0];
        ctrl.mem_unsigned = f3[2]; ctrl.reg_write = 1'b1; ctrl.wb_sel = WB_MEM;
        uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        bad = (f3[2] == 1'b1) || (f3 == 3'b011);
        ctrl.alu_src_b = SRC_B_IMM; ctrl.mem_write = 1'b1; ctrl.mem_size = f3[1:0];
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        if (f3 == 3'b001)      bad = (f7 != 7'b0000000);
        else if (f3 == 3'b101) bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        ctrl.alu_op = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
        ctrl.alu_src_b = SRC_B_IMM; ctrl.reg_write = 1'b1; uses_rs1 = 1'b1;
      end
      OP_REG: begin
        bad = !((f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
        ctrl.alu_op = alu_from_f3(f3, f7[5]);
        ctrl.reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: ;  // no execute-side effect; passes as a NOP
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl     = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
`ifdef CONTROL_OUT_ILLEGAL_TRAP_EN
      ctrl.illegal = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/id_control_stage.sv
// ID/EX control register: decode, load-use bubble insertion, stall/flush and a
// saturating bubble counter. CONTROL_OUT_ILLEGAL_TRAP_EN enables illegal_flag.
module id_control_stage
  import control_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic [CTRL_W-1:0] control_out,
  output logic              control_valid,
  output logic [4:0]        rd_out,
  output logic              illegal_flag,
  output logic [CNT_W-1:0]  bubble_count
);

  if (CTRL_W != $bits(control_type)) begin : g_bad_ctrl_w
    $error("CTRL_W must equal $bits(control_type)");
  end

  control_type dec_ctrl, ctrl_q;
  logic        uses_rs1, uses_rs2, hazard, accept;
  logic [4:0]  rs1, rs2, rd;
  state_e      state_q, state_d;

  control_decoder u_dec (
    .instr(instr_in), .ctrl(dec_ctrl), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .rs1(rs1), .rs2(rs2), .rd(rd)
  );

  assign control_valid = (state_q == ST_LOADED);
  assign control_out   = ctrl_q;

  // load in EX whose result the incoming instruction reads; x0 never conflicts
  assign hazard = control_valid && ctrl_q.mem_read && (rd_out != 5'd0) && instr_valid &&
                  ((uses_rs1 && (rs1 == rd_out)) || (uses_rs2 && (rs2 == rd_out)));
  assign instr_ready = !stall_in && !hazard && !flush_in;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_d = ST_EMPTY;
    if (flush_in)      state_d = ST_EMPTY;
    else if (stall_in) state_d = state_q;
    else if (hazard)   state_d = ST_BUBBLE;
    else if (accept)   state_d = ST_LOADED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q       <= '0;
      rd_out       <= '0;
      bubble_count <= '0;
    end else if (flush_in) begin
      ctrl_q <= '0;
      rd_out <= '0;
    end else if (stall_in) begin
      ctrl_q <= ctrl_q;
    end else if (hazard) begin
      ctrl_q <= '0;
      rd_out <= '0;
      if (bubble_count != {CNT_W{1'b1}}) bubble_count <= bubble_count + 1'b1;
    end else if (accept) begin
      ctrl_q <= dec_ctrl;
      rd_out <= dec_ctrl.reg_write ? rd : 5'd0;
    end else begin
      ctrl_q <= '0;
      rd_out <= '0;
    end
  end

`ifdef CONTROL_OUT_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          illegal_flag <= 1'b0;
    else if (accept && dec_ctrl.illegal) illegal_flag <= 1'b1;
  end
`else
  assign illegal_flag = 1'b0;
`endif

endmodule

// File: tb/tb_id_control_stage.sv
// Directed vector bench for id_control_stage: decode words, load-use bubbles,
// stall/flush priority, illegal handling and asynchronous reset.
module tb_id_control_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid, instr_ready, stall_in, flush_in;
  logic [31:0] control_out;
  logic        control_valid, illegal_flag;
  logic [4:0]  rd_out;
  logic [15:0] bubble_count;

  int checks = 0;
  int errors = 0;

  id_control_stage #(.CTRL_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .stall_in(stall_in), .flush_in(flush_in),
    .control_out(control_out), .control_valid(control_valid), .rd_out(rd_out),
    .illegal_flag(illegal_flag), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        valid, stall, flush;
    logic        e_ready;
    logic [31:0] e_ctrl;
    logic        e_vld;
    logic [4:0]  e_rd;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
    @(negedge clk);
    instr_in = i; instr_valid = v; stall_in = s; flush_in = f;
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] c, input logic v,
                          input logic [4:0] r, input logic [15:0] n);
    chk({tag, " control_out"}, control_out, c);
    chk({tag, " control_valid"}, {31'd0, control_valid}, {31'd0, v});
    chk({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, r});
    chk({tag, " bubble_count"}, {16'd0, bubble_count}, {16'd0, n});
  endtask

  function automatic vec_t mk(logic [31:0] i, logic v, logic s, logic f, logic rdy,
                              logic [31:0] c, logic ev, logic [4:0] r, logic [15:0] n);
    mk.instr = i; mk.valid = v; mk.stall = s; mk.flush = f; mk.e_ready = rdy;
    mk.e_ctrl = c; mk.e_vld = ev; mk.e_rd = r; mk.e_cnt = n;
  endfunction

  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_X6A = 32'h00228333;  // add x6,x5,x2
  localparam logic [31:0] ADD_X6B = 32'h00510333;  // add x6,x2,x5
  localparam logic [31:0] ADD_X3  = 32'h002081B3;
  localparam logic [31:0] W_LW    = 32'h00006940;
  localparam logic [31:0] W_ADD   = 32'h00002000;

  initial begin
    // instr, valid, stall, flush | ready, ctrl, valid, rd, count
    vt[0]  = mk(LW_X5,        1, 0, 0, 1, W_LW,         1, 5,  0);
    vt[1]  = mk(ADD_X6A,      1, 0, 0, 0, 32'h0,        0, 0,  1);
    vt[2]  = mk(ADD_X6A,      1, 0, 0, 1, W_ADD,        1, 6,  1);
    vt[3]  = mk(LW_X5,        1, 0, 0, 1, W_LW,         1, 5,  1);
    vt[4]  = mk(ADD_X6B,      1, 0, 0, 0, 32'h0,        0, 0,  2);
    vt[5]  = mk(ADD_X6B,      1, 0, 0, 1, W_ADD,        1, 6,  2);
    vt[6]  = mk(32'h0000A003, 1, 0, 0, 1, W_LW,         1, 0,  2);  // lw x0
    vt[7]  = mk(32'h002003B3, 1, 0, 0, 1, W_ADD,        1, 7,  2);  // add x7,x0,x2
    vt[8]  = mk(LW_X5,        1, 0, 0, 1, W_LW,         1, 5,  2);
    vt[9]  = mk(ADD_X6A,      1, 1, 0, 0, W_LW,         1, 5,  2);  // stall beats hazard
    vt[10] = mk(ADD_X6A,      1, 1, 1, 0, 32'h0,        0, 0,  2);  // flush beats stall
    vt[11] = mk(32'h0020A223, 1, 0, 0, 1, 32'h00000A40, 1, 0,  2);  // sw
    vt[12] = mk(32'h00208463, 1, 0, 0, 1, 32'h00010001, 1, 0,  2);  // beq
    vt[13] = mk(32'h00209463, 1, 0, 0, 1, 32'h00090001, 1, 0,  2);  // bne
    vt[14] = mk(32'h12345537, 1, 0, 0, 1, 32'h0000206A, 1, 10, 2);  // lui
    vt[15] = mk(32'h000000EF, 1, 0, 0, 1, 32'h0002A050, 1, 1,  2);  // jal x1
    vt[16] = mk(32'h00008067, 1, 0, 0, 1, 32'h0004A040, 1, 0,  2);  // jalr x0
    vt[17] = mk(32'h40208233, 1, 0, 0, 1, 32'h00002001, 1, 4,  2);  // sub
    vt[18] = mk(32'h4030D293, 1, 0, 0, 1, 32'h00002047, 1, 5,  2);  // srai
    vt[19] = mk(32'h0000C303, 1, 0, 0, 1, 32'h00007140, 1, 6,  2);  // lbu x6
    vt[20] = mk(ADD_X6A,      0, 0, 0, 1, 32'h0,        0, 0,  2);  // idle
    vt[21] = mk(ADD_X3,       1, 0, 1, 0, 32'h0,        0, 0,  2);  // flush
    vt[22] = mk(ADD_X3,       1, 0, 0, 1, W_ADD,        1, 3,  2);
    vt[23] = mk(LW_X5,        1, 0, 0, 1, W_LW,         1, 5,  2);
    vt[24] = mk(ADD_X6A,      1, 0, 1, 0, 32'h0,        0, 0,  2);  // flush, no bubble

    reset = 1'b1; instr_in = '0; instr_valid = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset", 32'h0, 1'b0, 5'd0, 16'd0);
    chk("reset illegal_flag", {31'd0, illegal_flag}, 32'd0);
    chk("reset instr_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      drive(vt[k].instr, vt[k].valid, vt[k].stall, vt[k].flush);
      chk($sformatf("v%0d instr_ready", k), {31'd0, instr_ready}, {31'd0, vt[k].e_ready});
      @(posedge clk);
      #1;
      chk_regs($sformatf("v%0d", k), vt[k].e_ctrl, vt[k].e_vld, vt[k].e_rd, vt[k].e_cnt);
    end

    // illegal encoding, then a legal one to show the flag is sticky
    drive(32'hFFFFFFFF, 1, 0, 0);
    @(posedge clk);
    #1;
`ifdef CONTROL_OUT_ILLEGAL_TRAP_EN
    chk_regs("illegal", 32'h00400000, 1'b1, 5'd0, 16'd2);
    chk("illegal flag", {31'd0, illegal_flag}, 32'd1);
`else
    chk_regs("illegal", 32'h0, 1'b1, 5'd0, 16'd2);
    chk("illegal flag", {31'd0, illegal_flag}, 32'd0);
`endif
    drive(ADD_X3, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_regs("post-illegal", W_ADD, 1'b1, 5'd3, 16'd2);
`ifdef CONTROL_OUT_ILLEGAL_TRAP_EN
    chk("sticky flag", {31'd0, illegal_flag}, 32'd1);
`else
    chk("sticky flag", {31'd0, illegal_flag}, 32'd0);
`endif

    // asynchronous reset while a valid entry and nonzero count are held
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_regs("midreset", 32'h0, 1'b0, 5'd0, 16'd0);
    chk("midreset illegal_flag", {31'd0, illegal_flag}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(LW_X5, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_regs("after reset", W_LW, 1'b1, 5'd5, 16'd0);
    drive(ADD_X6A, 1, 0, 0);
    chk("after reset hazard ready", {31'd0, instr_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk_regs("after reset bubble", 32'h0, 1'b0, 5'd0, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
